// File: rtl/axis_id_pkg.sv
// Shared definitions for the TID unpack/filter datapath: FSM state encoding,
// TUSER field positions and the last-beat tkeep shape check.
package axis_id_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Widest tkeep the contiguity helper accepts; callers zero-extend into it.
  localparam int unsigned KEEP_MAX_W = 256;

  // Number of tkeep bits for a given tdata width.
  function automatic int unsigned keep_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // TUSER is packed {tid, tkeep}, so tid starts right above tkeep.
  function automatic int unsigned tuser_tid_lsb(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Non-zero and filled from bit 0 upward with no holes (e.g. 0x0F, 0xFF).
  // Zero-extension keeps the all-ones case correct, because k+1 cannot wrap.
  function automatic logic tkeep_is_contig(input logic [KEEP_MAX_W-1:0] keep);
    return (keep != '0) && ((keep & (keep + KEEP_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer with registered outputs.
// s_ready_o comes straight from a flop, so it never depends combinationally
// on m_ready_i; the second slot absorbs the beat that was accepted while the
// output was stalled.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q, ready_d;
  logic             in_fire;

  assign in_fire = s_valid_i && ready_q;

  // Next-state: refill the output register from the skid slot first, otherwise
  // from the input; park the input beat in the skid slot while stalled.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || m_ready_i) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) begin
          out_data_d = s_data_i;
        end
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data_i;
    end
    ready_d = !skid_valid_d;
  end

  // Storage registers; ready stays low through reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign s_ready_o = ready_q;
  assign m_data_o  = out_data_q;
  assign m_valid_o = out_valid_q;

endmodule

// File: rtl/axis_id_unpack_filter.sv
// Splits packed TUSER {tid, tkeep}, drops packets with an out-of-range TID,
// flags malformed packets on their last beat and registers the result through
// a skid buffer. Per-ID statistics are built only when
// AXIS_ID_UNPACK_FILTER_STATS_EN is defined; otherwise stat_* read as zero.
//
//   state   | meaning
//   IDLE    | next accepted beat starts a packet
//   PASS    | inside a forwarded packet, tid latched
//   DROP    | inside a rejected packet, beats swallowed at full rate
module axis_id_unpack_filter
  import axis_id_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned TID_WIDTH   = 2,
  parameter int unsigned NUM_IDS     = 4,
  parameter int unsigned TUSER_WIDTH = TID_WIDTH + DATA_WIDTH / 8,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0]        s_axis_tuser,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [TID_WIDTH-1:0]          m_axis_tid,
  output logic [DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_terr,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [NUM_IDS*CNT_WIDTH-1:0]  stat_pkts,
  output logic [CNT_WIDTH-1:0]          stat_drops,
  output logic [CNT_WIDTH-1:0]          stat_errs
);

  localparam int unsigned KEEP_W = keep_width(DATA_WIDTH);
  localparam int unsigned PAY_W  = DATA_WIDTH + TID_WIDTH + KEEP_W + 2;
  localparam logic [KEEP_W-1:0]    KEEP_ONES = '1;
  localparam logic [TID_WIDTH:0]   NUM_IDS_L = (TID_WIDTH + 1)'(NUM_IDS);

  state_e               state_q, state_d;
  logic [TID_WIDTH-1:0] tid_q, tid_d;
  logic                 err_q, err_d;
  logic                 run_q;

  logic [TID_WIDTH-1:0]  tid_in;
  logic [KEEP_W-1:0]     keep_in;
  logic [KEEP_MAX_W-1:0] keep_ext;
  logic                  beat_fire, tid_ok, skid_ready;
  logic                  viol, terr_fwd, fwd;
  logic [TID_WIDTH-1:0]  tid_fwd;
  logic [PAY_W-1:0]      pay_in, pay_out;

  assign tid_in   = s_axis_tuser[tuser_tid_lsb(DATA_WIDTH) +: TID_WIDTH];
  assign keep_in  = s_axis_tuser[0 +: KEEP_W];
  assign keep_ext = KEEP_MAX_W'(keep_in);
  assign tid_ok   = {1'b0, tid_in} < NUM_IDS_L;

  // A DROP packet never waits on the output side, so only PASS/IDLE look at
  // skid space. run_q holds tready low until the first edge after reset.
  assign s_axis_tready = run_q && ((state_q == ST_DROP) || skid_ready);
  assign beat_fire     = s_axis_tvalid && s_axis_tready;

  // The tid check only exists once a tid has been latched (not on the first
  // beat); the full-keep check applies to every non-last beat, including the first.
  assign viol = ((state_q == ST_PASS) && (tid_in != tid_q)) ||
                (!s_axis_tlast && (keep_in != KEEP_ONES)) ||
                (s_axis_tlast && !tkeep_is_contig(keep_ext));
  assign terr_fwd = s_axis_tlast && (err_q || viol);

  // Packet FSM and sticky error tracking; advances only on accepted beats.
  always_comb begin
    state_d = state_q;
    tid_d   = tid_q;
    err_d   = err_q;
    fwd     = 1'b0;
    tid_fwd = tid_q;
    case (state_q)
      ST_IDLE: begin
        if (beat_fire) begin
          if (tid_ok) begin
            fwd     = 1'b1;
            tid_fwd = tid_in;
            tid_d   = tid_in;
            err_d   = !s_axis_tlast && viol;
            state_d = s_axis_tlast ? ST_IDLE : ST_PASS;
          end else begin
            state_d = s_axis_tlast ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_PASS: begin
        if (beat_fire) begin
          fwd   = 1'b1;
          err_d = !s_axis_tlast && (err_q || viol);
          if (s_axis_tlast) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (beat_fire && s_axis_tlast) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, latched tid, sticky error and the out-of-reset flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      tid_q   <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tid_q   <= tid_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
    end
  end

  assign pay_in = {s_axis_tdata, tid_fwd, keep_in, s_axis_tlast, terr_fwd};

  axis_skid_buffer #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clk       (aclk),
    .rst_n     (aresetn),
    .s_data_i  (pay_in),
    .s_valid_i (fwd),
    .s_ready_o (skid_ready),
    .m_data_o  (pay_out),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tid, m_axis_tkeep, m_axis_tlast, m_axis_terr} = pay_out;

`ifdef AXIS_ID_UNPACK_FILTER_STATS_EN
  logic                 pkt_done, drop_evt;
  logic [CNT_WIDTH-1:0] drops_q, errs_q;

  assign pkt_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign drop_evt = beat_fire && (state_q == ST_IDLE) && !tid_ok;

  for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_pkt_cnt
    logic [CNT_WIDTH-1:0] cnt_q;
    // Forwarded-packet count for this ID, taken when the last beat leaves.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        cnt_q <= '0;
      end else if (pkt_done && (m_axis_tid == TID_WIDTH'(gi))) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
    assign stat_pkts[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

  // Drop and error counters; both may step in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drops_q <= '0;
      errs_q  <= '0;
    end else begin
      if (drop_evt) begin
        drops_q <= drops_q + CNT_WIDTH'(1);
      end
      if (pkt_done && m_axis_terr) begin
        errs_q <= errs_q + CNT_WIDTH'(1);
      end
    end
  end

  assign stat_drops = drops_q;
  assign stat_errs  = errs_q;
`else
  assign stat_pkts  = '0;
  assign stat_drops = '0;
  assign stat_errs  = '0;
`endif

endmodule
